seq_detect_param: RTL

SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

---
 rtl/seq_detect_pkg.sv | 17 +
 rtl/seq_sat_counter.sv | 27 ++
 rtl/seq_detect_param.sv | 107 ++++++++++
 3 files changed

// File: rtl/seq_detect_pkg.sv
// Shared definitions for the parameterised serial sequence detector.
//   ovl_mode_e : overlap / non-overlap detection mode encoding
//   DEF_*      : configuration loaded by reset (pattern 101, length 3, overlap)
//   MIN_LEN    : shortest pattern length accepted by cfg_load
package seq_detect_pkg;

   typedef enum logic {
      OVL_OFF = 1'b0,   // non-overlapping: a match consumes its bits
      OVL_ON  = 1'b1    // overlapping: bits of a match may start the next one
   } ovl_mode_e;

   localparam logic [31:0] DEF_PAT = 32'b101;
   localparam int          DEF_LEN = 3;
   localparam ovl_mode_e   DEF_OVL = OVL_ON;
   localparam int          MIN_LEN = 2;

endpackage

// File: rtl/seq_sat_counter.sv
// Saturating up-counter used for the detector's match count.
//   clk   : rising-edge clock
//   clr_n : asynchronous active-low reset (count -> 0)
//   clr   : synchronous clear, takes priority over inc
//   inc   : increment by one, holding at all-ones
//   cnt   : current count
module seq_sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         clr_n,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != '1)) begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/seq_detect_param.sv
// Serial pattern detector with a run-time loadable pattern of 2..PAT_W bits.
//   clk       : rising-edge clock
//   clr_n     : asynchronous active-low reset
//   x/x_valid : serial data bit and its qualifier
//   cfg_load  : latch cfg_pat / cfg_len / cfg_ovl (illegal lengths rejected)
//   cfg_pat   : pattern, bit [cfg_len-1] arrives first, bit [0] last
//   cfg_len   : pattern length
//   cfg_ovl   : 1 = overlapping matches, 0 = non-overlapping
//   cnt_clr   : synchronous clear of match_cnt (wins over a same-edge match)
//   z         : registered one-cycle pulse the cycle after a match
//   match_cnt : saturating count of matches
//   cfg_err   : one-cycle pulse after a rejected cfg_load
module seq_detect_param
   import seq_detect_pkg::*;
#(
   parameter int PAT_W = 8,
   parameter int CNT_W = 8,
   parameter int LEN_W = $clog2(PAT_W + 1)
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic             x,
   input  logic             x_valid,
   input  logic             cfg_load,
   input  logic [PAT_W-1:0] cfg_pat,
   input  logic [LEN_W-1:0] cfg_len,
   input  logic             cfg_ovl,
   input  logic             cnt_clr,
   output logic             z,
   output logic [CNT_W-1:0] match_cnt,
   output logic             cfg_err
);

   logic [PAT_W-1:0] hist;
   logic [LEN_W-1:0] fill;
   logic [PAT_W-1:0] pat_q;
   logic [LEN_W-1:0] len_q;
   ovl_mode_e        ovl_q;

   logic [PAT_W-1:0] cand;
   logic [PAT_W-1:0] mask;
   logic             cfg_ok;
   logic             fill_ok;
   logic             match;

   // Window including the bit arriving on this edge.
   assign cand = {hist[PAT_W-2:0], x};

   // NOTE: always_comb gives every output a default before any conditional
   // assignment so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      mask = '0;
      for (int i = 0; i < PAT_W; i++) begin
         if (i < int'(len_q)) mask[i] = 1'b1;
      end
   end

   assign cfg_ok  = (cfg_len >= LEN_W'(MIN_LEN)) && (cfg_len <= LEN_W'(PAT_W));
   // fill counts bits before this one, so the current bit makes fill+1.
   assign fill_ok = ((LEN_W+1)'(fill) + (LEN_W+1)'(1)) >= (LEN_W+1)'(len_q);
   // cfg_load wins over x_valid: the bit is dropped and no compare happens.
   assign match   = x_valid && !cfg_load && fill_ok &&
                    (((cand ^ pat_q) & mask) == '0);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         hist    <= '0;
         fill    <= '0;
         pat_q   <= PAT_W'(DEF_PAT);
         len_q   <= LEN_W'(DEF_LEN);
         ovl_q   <= DEF_OVL;
         z       <= 1'b0;
         cfg_err <= 1'b0;
      end else begin
         z       <= match;
         cfg_err <= cfg_load && !cfg_ok;
         if (cfg_load) begin
            if (cfg_ok) begin
               pat_q <= cfg_pat;
               len_q <= cfg_len;
               ovl_q <= ovl_mode_e'(cfg_ovl);
               fill  <= '0;
            end
         end else if (x_valid) begin
            hist <= cand;
            if (match && (ovl_q == OVL_OFF)) begin
               fill <= '0;
            end else if (fill != LEN_W'(PAT_W)) begin
               fill <= fill + LEN_W'(1);
            end
         end
      end
   end

   seq_sat_counter #(
      .W (CNT_W)
   ) u_cnt (
      .clk   (clk),
      .clr_n (clr_n),
      .clr   (cnt_clr),
      .inc   (match),
      .cnt   (match_cnt)
   );

endmodule
